rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Parametrised multi-port register file with a write-to-read bypass and a per-register pending (scoreboard) bit, for the pipelined CPU datapath. It serves any number of decode-stage read ports and one writeback write port. Decode marks a destination as pending at issue. Writeback clears the mark when the value lands. Decode uses the per-port busy flags to stall on RAW hazards.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
- NRD, 2, number of read ports (at least 1)
- ZERO_REG, 0, if 1, register 0 always reads 0, is never busy, and ignores writes and issues
- BYPASS, 1, if 1, a same-cycle write is forwarded to matching read ports
- clk  in  1  clock; all state updates on its rising edge
- reset_n  in  1  reset, synchronous, active-low
- rd_addr  in  NRD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]; combinational
- rd_busy  out  NRD  port i's register is pending and not being satisfied this cycle; combinational
- wr_en  in  1  writeback write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- iss_en  in  1  issue enable: mark iss_addr pending
- iss_addr  in  ADDR_W  destination being issued
- busy_vec  out  DEPTH  registered pending bits, bit k = register k

## Operation
- Storage is DEPTH x DATA_W registers plus a DEPTH-bit pending vector.
- Write: on a clock edge with reset_n=1 and wr_en=1, mem[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Issue: on a clock edge with reset_n=1 and iss_en=1, pending[iss_addr] <= 1.
- Issue and write to the same address on the same edge: data is written and pending ends at 1, because the new producer wins.
- Issue and write to different addresses on the same edge: both take effect independently.
- Read port i, evaluated in this order:
  - ZERO_REG=1 and address 0 -> 0.
  - BYPASS=1, reset_n=1, wr_en=1 and wr_addr matches -> wr_data.
  - Otherwise -> mem[rd_addr_i].
- rd_busy[i] = pending[rd_addr_i], with two exceptions:
  - forced to 0 when ZERO_REG=1 and the address is 0;
  - forced to 0 when BYPASS=1, reset_n=1, wr_en=1 and wr_addr matches.
- Issue in the current cycle does not affect rd_busy until the following cycle.
- ZERO_REG=1: writes and issues to address 0 are dropped; mem[0] and pending[0] stay 0.
- All read ports are independent. Any ports may share an address.
- Reads have no side effects on state.

## Timing
- Reset: on a rising clk edge with reset_n=0, every mem entry and every pending bit goes to 0.
  - wr_en and iss_en are ignored on that edge.
- While reset_n=0, bypass and the busy override are disabled, so reads show stored contents.
  - After the first reset edge: rd_data = 0, rd_busy = 0, busy_vec = 0.
- Reset asserted mid-operation has priority on that edge over any write or issue.
  - A pending bit set before reset is cleared; no writeback is required.
- Read latency is 0 cycles (combinational from rd_addr, wr_*, and state).
- Write-to-read latency:
  - BYPASS=1: 0 cycles, visible in the same cycle.
  - BYPASS=0: visible from the cycle after the edge.
- Issue-to-busy latency is 1 edge. busy_vec reflects the pending bits directly from the flops.
- No handshake and no back-pressure; the block accepts every write and issue each cycle.
- Address width is exact (2**ADDR_W entries), so no out-of-range address exists.

## Test plan
1. Reset: preload all four entries, hold reset_n=0 for 1 edge -> rd_data=0 on every address, busy_vec=4'b0000; a concurrent wr_en to r1 has no effect.
2. Write then read: write r2=16'hBEEF, then read r2 on both ports next cycle -> both 16'hBEEF; bypass case: write r3=16'h1234 and read r3 in the same cycle -> 16'h1234 with BYPASS=1, old value 16'h0000 with BYPASS=0.
3. Scoreboard: issue r1 -> busy_vec=4'b0010 next cycle and rd_busy=1 on a port reading r1; writeback r1=16'h00AA -> rd_busy=0 in that same cycle (BYPASS=1) with rd_data=16'h00AA, and busy_vec=0 after the edge.
4. Simultaneous events: iss_en and wr_en both to r2 with data 16'h5555 -> mem[r2]=16'h5555 and pending[r2]=1; then iss r0 with wr r3 -> pending[0]=1 and pending[3]=0.
5. ZERO_REG=1: write r0=16'hFFFF and issue r0 -> r0 reads 0, rd_busy=0, busy_vec[0]=0.
6. Reset mid-operation: pending = 4'b1010, assert reset_n=0 for 1 edge -> busy_vec=0 and all data 0; with NRD=3, check three ports reading distinct and identical addresses return the correct values.

Source files
------------

// File: rtl/rf_scoreboard_if.sv
// Bundle of the register-file ports: decode read ports, writeback write
// port, issue marking and the raw pending vector.
interface rf_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int NRD    = 2
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic [DEPTH-1:0]      busy_vec;

  // Pipeline side: drives addresses, writes and issues.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Multi-port register file with same-cycle write bypass and a per-register
// pending bit used by decode to stall on RAW hazards.
module rf_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  rf_scoreboard_if.slave  rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  pend_reg;
  logic [DEPTH-1:0]  pend_next;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  iss_hit;

  // Per-entry decode; with ZERO_REG the zero register never accepts anything.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam bit HARD_ZERO = ZERO_REG && (gi == 0);

    assign wr_hit[gi]  = !HARD_ZERO && rf.wr_en  && (rf.wr_addr  == ADDR_W'(gi));
    assign iss_hit[gi] = !HARD_ZERO && rf.iss_en && (rf.iss_addr == ADDR_W'(gi));

    // A new issue to the same register wins over the retiring writeback.
    assign pend_next[gi] = iss_hit[gi] ? 1'b1 :
                           wr_hit[gi]  ? 1'b0 : pend_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_reg[k] <= '0;
      end
      pend_reg <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_hit[k]) begin
          mem_reg[k] <= rf.wr_data;
        end
      end
      pend_reg <= pend_next;
    end
  end

  assign rf.busy_vec = pend_reg;

  // Read ports: zero register first, then the in-flight writeback, then storage.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero_hit;
    logic              byp_hit;

    assign ra       = rf.rd_addr[gi*ADDR_W +: ADDR_W];
    assign zero_hit = ZERO_REG && (ra == '0);
    assign byp_hit  = BYPASS && reset_n && rf.wr_en && (rf.wr_addr == ra);

    assign rf.rd_data[gi*DATA_W +: DATA_W] = zero_hit ? '0         :
                                             byp_hit  ? rf.wr_data : mem_reg[ra];
    assign rf.rd_busy[gi] = !zero_hit && !byp_hit && pend_reg[ra];
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench: vector table on the default configuration, hand sequences
// for BYPASS=0 and for ZERO_REG=1 with three read ports.
module tb_rf_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   n_chk  = 0;
  int   n_fail = 0;

  rf_scoreboard_if #(.DATA_W(16), .ADDR_W(2), .NRD(2)) b0 ();
  rf_scoreboard_if #(.DATA_W(16), .ADDR_W(2), .NRD(2)) b1 ();
  rf_scoreboard_if #(.DATA_W(16), .ADDR_W(2), .NRD(3)) b2 ();

  rf_scoreboard #(.DATA_W(16), .ADDR_W(2), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b1))
    u0 (.clk(clk), .reset_n(rst0), .rf(b0));
  rf_scoreboard #(.DATA_W(16), .ADDR_W(2), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b0))
    u1 (.clk(clk), .reset_n(rst1), .rf(b1));
  rf_scoreboard #(.DATA_W(16), .ADDR_W(2), .NRD(3), .ZERO_REG(1'b1), .BYPASS(1'b1))
    u2 (.clk(clk), .reset_n(rst2), .rf(b2));

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic        ie;
    logic [1:0]  ia;
    logic [1:0]  ra0;
    logic [1:0]  ra1;
    logic        chk;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  bz;
    logic [3:0]  bv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic we, input logic [1:0] wa,
                     input logic [15:0] wd, input logic ie, input logic [1:0] ia,
                     input logic [1:0] ra0, input logic [1:0] ra1, input logic chk,
                     input logic [15:0] d0, input logic [15:0] d1,
                     input logic [1:0] bz, input logic [3:0] bv);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.ra0 = ra0; v.ra1 = ra1; v.chk = chk;
    v.d0 = d0; v.d1 = d1; v.bz = bz; v.bv = bv;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive1(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                        input logic ie, input logic [1:0] ia, input logic [3:0] ra);
    b1.wr_en = we; b1.wr_addr = wa; b1.wr_data = wd;
    b1.iss_en = ie; b1.iss_addr = ia; b1.rd_addr = ra;
  endtask

  task automatic drive2(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                        input logic ie, input logic [1:0] ia, input logic [5:0] ra);
    b2.wr_en = we; b2.wr_addr = wa; b2.wr_data = wd;
    b2.iss_en = ie; b2.iss_addr = ia; b2.rd_addr = ra;
  endtask

  task automatic check1(input int idx, input logic [31:0] d, input logic [1:0] bz,
                        input logic [3:0] bv);
    #2;
    check("u1_rd_data", idx, 48'(b1.rd_data), 48'(d));
    check("u1_rd_busy", idx, 48'(b1.rd_busy), 48'(bz));
    check("u1_busy_vec", idx, 48'(b1.busy_vec), 48'(bv));
    $display("u1 step %0d: rd_data=%h rd_busy=%b busy_vec=%b", idx, b1.rd_data, b1.rd_busy, b1.busy_vec);
    @(negedge clk);
  endtask

  task automatic check2(input int idx, input logic [47:0] d, input logic [2:0] bz,
                        input logic [3:0] bv);
    #2;
    check("u2_rd_data", idx, b2.rd_data, d);
    check("u2_rd_busy", idx, 48'(b2.rd_busy), 48'(bz));
    check("u2_busy_vec", idx, 48'(b2.busy_vec), 48'(bv));
    $display("u2 step %0d: rd_data=%h rd_busy=%b busy_vec=%b", idx, b2.rd_data, b2.rd_busy, b2.busy_vec);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    b0.wr_en = 1'b0; b0.wr_addr = '0; b0.wr_data = '0; b0.iss_en = 1'b0; b0.iss_addr = '0; b0.rd_addr = '0;
    drive1(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 4'h0);
    drive2(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 6'h0);

    //   rst we wa  wd       ie ia  ra0 ra1 chk d0       d1       bz     bv
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 4'b0000);
    add(1, 1, 0, 16'h1111, 0, 0, 0, 1, 1, 16'h1111, 16'h0000, 2'b00, 4'b0000);
    add(1, 1, 1, 16'h2222, 0, 0, 0, 1, 1, 16'h1111, 16'h2222, 2'b00, 4'b0000);
    add(1, 1, 2, 16'h3333, 0, 0, 2, 1, 1, 16'h3333, 16'h2222, 2'b00, 4'b0000);
    add(1, 1, 3, 16'h4444, 0, 0, 3, 2, 1, 16'h4444, 16'h3333, 2'b00, 4'b0000);
    // Reset edge with concurrent write/issue: reads show stored contents
    add(0, 1, 1, 16'hDEAD, 1, 2, 1, 3, 1, 16'h2222, 16'h4444, 2'b00, 4'b0000);
    add(1, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 2'b00, 4'b0000);
    add(1, 0, 0, 16'h0000, 0, 0, 2, 3, 1, 16'h0000, 16'h0000, 2'b00, 4'b0000);
    add(1, 1, 2, 16'hBEEF, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 2'b00, 4'b0000);
    add(1, 0, 0, 16'h0000, 0, 0, 2, 2, 1, 16'hBEEF, 16'hBEEF, 2'b00, 4'b0000);
    add(1, 1, 3, 16'h1234, 0, 0, 3, 2, 1, 16'h1234, 16'hBEEF, 2'b00, 4'b0000);
    // Scoreboard: issue r1, then writeback clears busy in the same cycle
    add(1, 0, 0, 16'h0000, 1, 1, 1, 3, 1, 16'h0000, 16'h1234, 2'b00, 4'b0000);
    add(1, 0, 0, 16'h0000, 0, 0, 1, 2, 1, 16'h0000, 16'hBEEF, 2'b01, 4'b0010);
    add(1, 1, 1, 16'h00AA, 0, 0, 1, 1, 1, 16'h00AA, 16'h00AA, 2'b00, 4'b0010);
    add(1, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 16'h00AA, 16'h0000, 2'b00, 4'b0000);
    // Simultaneous issue and write
    add(1, 1, 2, 16'h5555, 1, 2, 2, 3, 1, 16'h5555, 16'h1234, 2'b00, 4'b0000);
    add(1, 1, 3, 16'h7777, 1, 0, 2, 3, 1, 16'h5555, 16'h7777, 2'b01, 4'b0100);
    add(1, 0, 0, 16'h0000, 0, 0, 0, 3, 1, 16'h0000, 16'h7777, 2'b01, 4'b0101);
    add(1, 1, 2, 16'h6666, 1, 3, 2, 0, 1, 16'h6666, 16'h0000, 2'b10, 4'b0101);
    add(1, 1, 0, 16'hABCD, 1, 1, 3, 0, 1, 16'h7777, 16'hABCD, 2'b01, 4'b1001);
    // Reset with pending = 1010: no bypass or override while reset_n=0
    add(0, 1, 2, 16'hFFFF, 1, 0, 1, 2, 1, 16'h00AA, 16'h6666, 2'b01, 4'b1010);
    add(1, 0, 0, 16'h0000, 0, 0, 1, 3, 1, 16'h0000, 16'h0000, 2'b00, 4'b0000);
    add(1, 0, 0, 16'h0000, 0, 0, 0, 2, 1, 16'h0000, 16'h0000, 2'b00, 4'b0000);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst0 = tbl[i].rst;
      b0.wr_en = tbl[i].we;   b0.wr_addr = tbl[i].wa;  b0.wr_data = tbl[i].wd;
      b0.iss_en = tbl[i].ie;  b0.iss_addr = tbl[i].ia;
      b0.rd_addr = {tbl[i].ra1, tbl[i].ra0};
      #2;
      if (tbl[i].chk) begin
        check("u0_rd_data0", i, 48'(b0.rd_data[15:0]),  48'(tbl[i].d0));
        check("u0_rd_data1", i, 48'(b0.rd_data[31:16]), 48'(tbl[i].d1));
        check("u0_rd_busy",  i, 48'(b0.rd_busy),        48'(tbl[i].bz));
        check("u0_busy_vec", i, 48'(b0.busy_vec),       48'(tbl[i].bv));
      end
      $display("u0 vec %0d: rd_data=%h rd_busy=%b busy_vec=%b", i, b0.rd_data, b0.rd_busy, b0.busy_vec);
      @(negedge clk);
    end
    rst0 = 1'b0;

    // BYPASS=0: writes become visible only after the edge; no busy override
    rst1 = 1'b1;
    drive1(1'b1, 2'd3, 16'h1234, 1'b0, 2'd0, {2'd3, 2'd3});
    check1(0, {16'h0000, 16'h0000}, 2'b00, 4'b0000);
    drive1(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, {2'd3, 2'd3});
    check1(1, {16'h1234, 16'h1234}, 2'b00, 4'b0000);
    drive1(1'b1, 2'd0, 16'hFFFF, 1'b1, 2'd1, {2'd1, 2'd0});
    check1(2, {16'h0000, 16'h0000}, 2'b00, 4'b0000);
    drive1(1'b1, 2'd1, 16'h00AA, 1'b0, 2'd0, {2'd0, 2'd1});
    check1(3, {16'hFFFF, 16'h0000}, 2'b01, 4'b0010);
    drive1(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, {2'd0, 2'd1});
    check1(4, {16'hFFFF, 16'h00AA}, 2'b00, 4'b0000);

    // ZERO_REG=1, NRD=3
    rst2 = 1'b1;
    drive2(1'b1, 2'd0, 16'hFFFF, 1'b1, 2'd0, {2'd0, 2'd0, 2'd0});
    check2(0, 48'h0, 3'b000, 4'b0000);
    drive2(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, {2'd0, 2'd1, 2'd0});
    check2(1, 48'h0, 3'b000, 4'b0000);
    drive2(1'b1, 2'd1, 16'h1111, 1'b1, 2'd3, {2'd1, 2'd2, 2'd1});
    check2(2, {16'h1111, 16'h0000, 16'h1111}, 3'b000, 4'b0000);
    drive2(1'b1, 2'd2, 16'h2222, 1'b1, 2'd1, {2'd3, 2'd2, 2'd1});
    check2(3, {16'h0000, 16'h2222, 16'h1111}, 3'b100, 4'b1000);
    drive2(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, {2'd1, 2'd2, 2'd1});
    check2(4, {16'h1111, 16'h2222, 16'h1111}, 3'b101, 4'b1010);
    rst2 = 1'b0;
    drive2(1'b1, 2'd2, 16'hDEAD, 1'b0, 2'd0, {2'd3, 2'd2, 2'd1});
    check2(5, {16'h0000, 16'h2222, 16'h1111}, 3'b101, 4'b1010);
    rst2 = 1'b1;
    drive2(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, {2'd2, 2'd2, 2'd1});
    check2(6, 48'h0, 3'b000, 4'b0000);
    drive2(1'b1, 2'd1, 16'hAAAA, 1'b0, 2'd0, {2'd1, 2'd1, 2'd1});
    check2(7, {16'hAAAA, 16'hAAAA, 16'hAAAA}, 3'b000, 4'b0000);
    drive2(1'b1, 2'd2, 16'hBBBB, 1'b0, 2'd0, {2'd0, 2'd2, 2'd1});
    check2(8, {16'h0000, 16'hBBBB, 16'hAAAA}, 3'b000, 4'b0000);
    drive2(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, {2'd2, 2'd2, 2'd0});
    check2(9, {16'hBBBB, 16'hBBBB, 16'h0000}, 3'b000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
